uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 24 ++
 rtl/uart_tx.sv | 105 ++++++++++
 tb/tb_uart_tx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Signal bundle between the byte source (master) and the uart_tx serializer (slave).
interface uart_tx_if;
   logic [7:0] IN_Data;
   logic       byte_ready;
   logic       tx_byte;
   logic       Tx;
   logic       tx_busy;

   modport master (
      output IN_Data,
      output byte_ready,
      output tx_byte,
      input  Tx,
      input  tx_busy
   );

   modport slave (
      input  IN_Data,
      input  byte_ready,
      input  tx_byte,
      output Tx,
      output tx_busy
   );
endinterface

// File: rtl/uart_tx.sv
// Transmit-only 8N1 UART serializer with a separate holding register and shift register.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 85
) (
   input logic      CLK,
   input logic      reset,
   uart_tx_if.slave bus
);
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    idx, idx_d;
   logic [7:0]    hold, shift;
   logic          valid;
   logic          tx_q, busy_q, tx_d, busy_d;
   logic          bit_end, start;

   assign bit_end = (cnt == LAST);
   assign start   = (state == IDLE) && bus.tx_byte && valid;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         idx   <= idx_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = '0;
      idx_d   = idx;
      case (state)
         IDLE: begin
            idx_d = '0;
            if (start) state_d = START;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
            end else cnt_d = cnt + 1'b1;
         end
         DATA: begin
            if (bit_end) begin
               if (idx == 3'd7) begin
                  state_d = STOP;
                  idx_d   = '0;
               end else idx_d = idx + 3'd1;
            end else cnt_d = cnt + 1'b1;
         end
         STOP: begin
            if (bit_end) state_d = IDLE;
            else cnt_d = cnt + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is decoded from the next state so Tx/tx_busy can be registered
   // and still change on the very edge the state does.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = 1'b1;
      case (state_d)
         IDLE:    busy_d = 1'b0;
         START:   tx_d   = 1'b0;
         DATA:    tx_d   = shift[idx_d];
         STOP:    tx_d   = 1'b1;
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         hold   <= '0;
         shift  <= '0;
         valid  <= 1'b0;
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         busy_q <= busy_d;
         if (start) shift <= hold;
         // A load on the start edge re-arms valid for the newly captured byte.
         if (bus.byte_ready) begin
            hold  <= bus.IN_Data;
            valid <= 1'b1;
         end else if (start) begin
            valid <= 1'b0;
         end
      end
   end

   assign bus.Tx      = tx_q;
   assign bus.tx_busy = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-timing reference model plus table-driven and hand-written frames.
module tb_uart_tx;
   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   uart_tx_if bus85 ();
   uart_tx_if bus4 ();

   uart_tx #(.CLKS_PER_BIT(85)) dut85 (.CLK(CLK), .reset(reset), .bus(bus85));
   uart_tx #(.CLKS_PER_BIT(4))  dut4  (.CLK(CLK), .reset(reset), .bus(bus4));

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int clk_of(input int s);
      return (s == 0) ? 85 : 4;
   endfunction

   function automatic logic get_tx(input int s);
      return (s == 0) ? bus85.Tx : bus4.Tx;
   endfunction

   function automatic logic get_busy(input int s);
      return (s == 0) ? bus85.tx_busy : bus4.tx_busy;
   endfunction

   task automatic drive(input int s, input logic [7:0] d, input logic br, input logic req);
      if (s == 0) begin
         bus85.IN_Data = d; bus85.byte_ready = br; bus85.tx_byte = req;
      end else begin
         bus4.IN_Data = d; bus4.byte_ready = br; bus4.tx_byte = req;
      end
   endtask

   // Reference model: a frame is a 10-bit vector replayed at CLKS_PER_BIT cycles per bit.
   logic [7:0] in_d   [2];
   logic       in_br  [2];
   logic       in_req [2];
   assign in_d[0] = bus85.IN_Data;  assign in_br[0] = bus85.byte_ready;  assign in_req[0] = bus85.tx_byte;
   assign in_d[1] = bus4.IN_Data;   assign in_br[1] = bus4.byte_ready;   assign in_req[1] = bus4.tx_byte;

   bit         m_active [2];
   int         m_t      [2];
   logic [9:0] m_frame  [2];
   logic [7:0] m_hold   [2];
   bit         m_valid  [2];

   always @(posedge CLK or negedge reset) begin
      for (int s = 0; s < 2; s++) begin
         if (!reset) begin
            m_active[s] <= 1'b0;
            m_t[s]      <= 0;
            m_frame[s]  <= '1;
            m_hold[s]   <= '0;
            m_valid[s]  <= 1'b0;
         end else begin
            if (m_active[s]) begin
               m_t[s] <= m_t[s] + 1;
               if (m_t[s] + 1 == 10 * clk_of(s)) m_active[s] <= 1'b0;
            end else if (m_valid[s] && in_req[s]) begin
               m_active[s] <= 1'b1;
               m_t[s]      <= 0;
               m_frame[s]  <= {1'b1, m_hold[s], 1'b0};
            end
            if (in_br[s]) begin
               m_hold[s]  <= in_d[s];
               m_valid[s] <= 1'b1;
            end else if (!m_active[s] && m_valid[s] && in_req[s]) begin
               m_valid[s] <= 1'b0;
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (mon_en) begin
         for (int s = 0; s < 2; s++) begin
            logic e;
            e = m_active[s] ? m_frame[s][m_t[s] / clk_of(s)] : 1'b1;
            chk((s == 0) ? "mon85_tx" : "mon4_tx", int'(get_tx(s)), int'(e));
            chk((s == 0) ? "mon85_busy" : "mon4_busy", int'(get_busy(s)), int'(m_active[s]));
         end
      end
   end

   task automatic load(input int s, input logic [7:0] d);
      @(negedge CLK);
      drive(s, d, 1'b1, 1'b0);
      @(negedge CLK);
      drive(s, d, 1'b0, 1'b1);
   endtask

   task automatic wait_busy(input int s, input string name);
      int n = 0;
      while (!get_busy(s) && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk(name, int'(get_busy(s)), 1);
   endtask

   // Entered on the first negedge with tx_busy high; returns on the first with it low.
   task automatic capture(input int s, input int load_at, input logic [7:0] load_d,
                          output logic [9:0] fr, output int cnt);
      int c = clk_of(s);
      fr  = '1;
      cnt = 0;
      while (get_busy(s) && cnt < 12 * c) begin
         if ((cnt % c) == (c / 2) && (cnt / c) < 10) fr[cnt / c] = get_tx(s);
         if (load_at >= 0 && cnt == load_at)     drive(s, load_d, 1'b1, 1'b1);
         if (load_at >= 0 && cnt == load_at + 1) drive(s, load_d, 1'b0, 1'b1);
         @(negedge CLK);
         cnt++;
      end
   endtask

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   initial begin
      vec_t       vecs [6];
      logic [9:0] fr;
      int         cnt, n;

      vecs[0] = '{0, 8'hAA, 10'b1101010100};
      vecs[1] = '{0, 8'h00, 10'b1000000000};
      vecs[2] = '{0, 8'hFF, 10'b1111111110};
      vecs[3] = '{1, 8'h00, 10'b1000000000};
      vecs[4] = '{1, 8'hFF, 10'b1111111110};
      vecs[5] = '{1, 8'hA5, 10'b1101001010};

      drive(0, 8'h00, 1'b0, 1'b0);
      drive(1, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_tx85", int'(bus85.Tx), 1);
      chk("rst_busy85", int'(bus85.tx_busy), 0);
      chk("rst_tx4", int'(bus4.Tx), 1);
      chk("rst_busy4", int'(bus4.tx_busy), 0);
      reset  = 1'b1;
      mon_en = 1'b1;

      // Request with nothing loaded must not start a frame.
      drive(0, 8'h00, 1'b0, 1'b1);
      drive(1, 8'h00, 1'b0, 1'b1);
      n = 0;
      repeat (100) begin
         @(negedge CLK);
         if (bus85.Tx && !bus85.tx_busy && bus4.Tx && !bus4.tx_busy) n++;
      end
      chk("noload_idle", n, 100);
      drive(0, 8'h00, 1'b0, 1'b0);
      drive(1, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         load(vecs[i].sel, vecs[i].data);
         wait_busy(vecs[i].sel, "vec_start");
         drive(vecs[i].sel, vecs[i].data, 1'b0, 1'b0);
         capture(vecs[i].sel, -1, 8'h00, fr, cnt);
         chk("vec_frame", int'(fr), int'(vecs[i].frame));
         chk("vec_busy_len", cnt, 10 * clk_of(vecs[i].sel));
         repeat (3) @(negedge CLK);
      end

      // Request held high after a frame: no retransmission.
      load(0, 8'hAA);
      wait_busy(0, "noretx_start");
      capture(0, -1, 8'h00, fr, cnt);
      chk("noretx_frame", int'(fr), int'(10'b1101010100));
      chk("noretx_len", cnt, 850);
      n = 0;
      repeat (2000) begin
         @(negedge CLK);
         if (bus85.tx_busy) n++;
      end
      chk("noretx_busy", n, 0);
      drive(0, 8'h00, 1'b0, 1'b0);

      // Load during busy, then back-to-back with exactly one idle cycle.
      load(0, 8'hAA);
      wait_busy(0, "b2b_start");
      capture(0, 300, 8'h55, fr, cnt);
      chk("b2b_frame1", int'(fr), int'(10'b1101010100));
      chk("b2b_len1", cnt, 850);
      n = 0;
      while (!bus85.tx_busy && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("b2b_gap", n, 1);
      drive(0, 8'h00, 1'b0, 1'b0);
      capture(0, -1, 8'h00, fr, cnt);
      chk("b2b_frame2", int'(fr), int'(10'b1010101010));
      chk("b2b_len2", cnt, 850);
      repeat (3) @(negedge CLK);

      // Asynchronous reset in the middle of data bit 3 (0xC3: bit 3 is 0).
      load(0, 8'hC3);
      wait_busy(0, "rstmid_start");
      repeat (4 * 85 + 40) @(negedge CLK);
      chk("rstmid_pre_tx", int'(bus85.Tx), 0);
      chk("rstmid_pre_busy", int'(bus85.tx_busy), 1);
      #2 reset = 1'b0;
      #1;
      chk("rstmid_tx", int'(bus85.Tx), 1);
      chk("rstmid_busy", int'(bus85.tx_busy), 0);
      repeat (2) @(negedge CLK);
      reset = 1'b1;
      n = 0;
      repeat (100) begin
         @(negedge CLK);
         if (bus85.tx_busy || !bus85.Tx) n++;
      end
      chk("rstmid_no_frame", n, 0);
      load(0, 8'h3C);
      wait_busy(0, "rstmid_reload");
      drive(0, 8'h3C, 1'b0, 1'b0);
      capture(0, -1, 8'h00, fr, cnt);
      chk("rstmid_frame", int'(fr), int'(10'b1001111000));
      chk("rstmid_len", cnt, 850);

      // Random traffic on both instances, checked by the model every cycle.
      repeat (4000) begin
         @(negedge CLK);
         for (int s = 0; s < 2; s++)
            drive(s, 8'($urandom), ($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0));
      end
      drive(0, 8'h00, 1'b0, 1'b0);
      drive(1, 8'h00, 1'b0, 1'b0);
      repeat (900) @(negedge CLK);
      chk("end_idle85", int'(bus85.tx_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
